// File: rtl/vram_rect_fill_pkg.sv
// Shared constants, colour codes and fill-engine state encoding for the
// 80x60 video RAM rectangle-fill engine.
package vram_rect_fill_pkg;

    localparam int H_RES   = 80;
    localparam int V_RES   = 60;
    localparam int COORD_W = 8;
    localparam int ADDR_W  = 13;
    localparam int COLOR_W = 3;

    // RGB bit order: {R, G, B}
    localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'd0;
    localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'd1;
    localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'd2;
    localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'd3;
    localparam logic [COLOR_W-1:0] COLOR_RED     = 3'd4;
    localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'd5;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'd6;
    localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'd7;

    // Screen limits at coordinate width, row stride at address width
    localparam logic [COORD_W-1:0] H_LIMIT    = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_LIMIT    = COORD_W'(V_RES);
    localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_CHECK,
        FILL_RUN,
        FILL_DONE
    } fill_state_t;

    // Linear address of the first pixel of a row; callers guarantee row < V_RES
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [COORD_W-1:0] row);
        return ADDR_W'(row) * ROW_STRIDE;
    endfunction

endpackage

// File: rtl/vram_write_arbiter.sv
// Fixed-priority VRAM write-port mux: CPU pixel writes always win over the
// fill stream. Owns the registered VRAM outputs and tells the fill engine
// when it has been held off.
module vram_write_arbiter
    import vram_rect_fill_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [COLOR_W-1:0] cpu_color,
    input  logic               fill_req,
    input  logic [ADDR_W-1:0]  fill_addr,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               stall,
    output logic               vram_we,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [COLOR_W-1:0] vram_data
);

    // Any CPU write takes the port, so a pending fill pixel must hold
    assign stall = cpu_we;

    // Register the winning write; idle cycles drop the enable only
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else if (cpu_we) begin
            vram_we   <= 1'b1;
            vram_addr <= cpu_addr;
            vram_data <= cpu_color;
        end else if (fill_req) begin
            vram_we   <= 1'b1;
            vram_addr <= fill_addr;
            vram_data <= fill_color;
        end else begin
            vram_we   <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: writes one colour over an inclusive rectangle of
// the 80x60 VRAM, one pixel per clock, sharing the write port with the CPU.
//
// state      | meaning
// FILL_IDLE  | waiting for iStart; corners and colour latched on request
// FILL_CHECK | bounds check; reject with oError or set up the first row
// FILL_RUN   | emit one pixel per cycle not taken by a CPU write
// FILL_DONE  | pulse oDone, drop oBusy, return to idle
module vram_rect_fill
    import vram_rect_fill_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iXi,
    input  logic [COORD_W-1:0] iYi,
    input  logic [COORD_W-1:0] iXf,
    input  logic [COORD_W-1:0] iYf,
    input  logic [COLOR_W-1:0] iColor,
    input  logic               iCpuWe,
    input  logic [ADDR_W-1:0]  iCpuAddr,
    input  logic [COLOR_W-1:0] iCpuColor,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic               oVramWe,
    output logic [ADDR_W-1:0]  oVramAddr,
    output logic [COLOR_W-1:0] oVramData
);

    fill_state_t        state;
    logic [COORD_W-1:0] x_i, y_i, x_f, y_f;
    logic [COORD_W-1:0] x, y;
    logic [COLOR_W-1:0] color;
    logic [ADDR_W-1:0]  row_base;
    logic               busy, done, error;
    logic               stall;
    logic               fill_req;
    logic [ADDR_W-1:0]  fill_addr;

    assign fill_req  = (state == FILL_RUN);
    assign fill_addr = row_base + ADDR_W'(x);

    assign oBusy  = busy;
    assign oDone  = done;
    assign oError = error;

    // Sequencing: latch request, validate, raster-scan the rectangle, finish
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= FILL_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            x_i      <= '0;
            y_i      <= '0;
            x_f      <= '0;
            y_f      <= '0;
            x        <= '0;
            y        <= '0;
            color    <= '0;
            row_base <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                FILL_IDLE: begin
                    if (iStart) begin
                        x_i   <= iXi;
                        y_i   <= iYi;
                        x_f   <= iXf;
                        y_f   <= iYf;
                        color <= iColor;
                        state <= FILL_CHECK;
                    end
                end
                FILL_CHECK: begin
                    if ((x_i > x_f) || (y_i > y_f) || (x_f >= H_LIMIT) || (y_f >= V_LIMIT)) begin
                        error <= 1'b1;
                        state <= FILL_IDLE;
                    end else begin
                        x        <= x_i;
                        y        <= y_i;
                        row_base <= row_base_of(y_i);
                        busy     <= 1'b1;
                        state    <= FILL_RUN;
                    end
                end
                FILL_RUN: begin
                    // A CPU write this cycle means the current pixel is re-offered next cycle
                    if (!stall) begin
                        if (x == x_f) begin
                            x        <= x_i;
                            y        <= y + 1'b1;
                            row_base <= row_base + ROW_STRIDE;
                            if (y == y_f) begin
                                state <= FILL_DONE;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                FILL_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= FILL_IDLE;
                end
                default: state <= FILL_IDLE;
            endcase
        end
    end

    vram_write_arbiter u_arbiter (
        .clock      (Clock),
        .reset_n    (Reset),
        .cpu_we     (iCpuWe),
        .cpu_addr   (iCpuAddr),
        .cpu_color  (iCpuColor),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_color (color),
        .stall      (stall),
        .vram_we    (oVramWe),
        .vram_addr  (oVramAddr),
        .vram_data  (oVramData)
    );

endmodule
